mem_arbiter: RTL
================

# mem_arbiter

Sequencer and two-way arbiter for the processor's single-port program/data RAM. Shares the RAM between the CPU control path (instruction fetch, operand read, store) and the switch-driven program loader. It grants one requester at a time, drives the RAM port, waits out the read latency, and returns data with a one-cycle acknowledge. It sits between the control unit/datapath and the RAM.

## Interface
Parameters:
- AW, 5, address width (32-word RAM)
- DW, 8, data width
- RD_LAT, 1, RAM read latency in cycles (≥1; synchronous RAM)

Ports:
- CLOCK_50  in  1  sole clock; all state updates on rising edge
- reset  in  1  one clock; reset is synchronous and active-low
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  one-cycle completion pulse for CPU
- cpu_rdata  out  DW  CPU read data, registered
- ld_req, ld_we, ld_addr, ld_wdata  in  1/1/AW/DW  loader request, same meaning as CPU
- ld_ack  out  1  one-cycle completion pulse for loader
- ld_rdata  out  DW  loader read data, registered
- ld_lock  in  1  1 = loader exclusive; CPU is never granted
- mem_addr  out  AW  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid RD_LAT cycles after address
- busy  out  1  transaction in progress (state ≠ IDLE)
- owner  out  1  0 = CPU, 1 = loader; owner of current or last transaction

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE: eligible requesters are cpu_req & ~ld_lock, and ld_req. If neither is eligible, stay. If one is eligible, grant it. If both are eligible, grant the requester that was not served last (round-robin pointer `last`). Latch owner, we, addr, wdata of the winner. Next state is ISSUE.
- ISSUE (1 cycle): mem_addr = latched addr; mem_we = latched we; mem_wdata = latched wdata. A write goes to ACK. A read loads the counter with RD_LAT and goes to WAIT.
- WAIT (RD_LAT cycles): mem_addr is held and mem_we = 0. On the last WAIT cycle, mem_rdata is captured into the owner's rdata register. Next state is ACK.
- ACK (1 cycle): the owner's ack = 1 and the other ack = 0. `last` is set to owner. Next state is IDLE.
- Requester rule: req drops on the edge ending the ACK cycle. A req still high in the following IDLE cycle is a new request.
- Request inputs are ignored outside IDLE. If req drops mid-transaction, the transaction still completes and ack still pulses.
- ld_lock is sampled only in IDLE. Asserting it mid-transaction does not abort a CPU access.
- The non-owner's rdata register holds its value. An rdata register changes only on completion of its owner's read.
- mem_we is asserted only in ISSUE for writes. It is never high for 2 consecutive cycles.
- Reset (reset = 0 at a rising edge), whether idle or mid-operation, does the following:
  - state IDLE, with any in-flight transaction aborted and no ack.
  - cpu_ack = ld_ack = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - cpu_rdata = ld_rdata = 0, busy = 0, owner = 0.
  - `last` = 1, so the CPU wins the first tie.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from any req to any output.
- Write latency: req seen in IDLE at cycle 0, mem_we = 1 in cycle 1, ack in cycle 2. Back-to-back writes from one requester can complete at most every 3 cycles (ACK, IDLE, ISSUE).
- Read latency: IDLE at cycle 0, ISSUE at cycle 1, WAIT at cycles 2..RD_LAT+1, ack at cycle RD_LAT+2. rdata is valid in the ack cycle and holds afterward.
- busy is high from ISSUE through ACK inclusive.

## Test plan
- Reset, then a CPU write: set cpu_addr=5'h03, cpu_wdata=8'hA5, cpu_we=1, and hold cpu_req.
  - Required: mem_we=1 with mem_addr=3 and mem_wdata=A5 in cycle 1 only.
  - Required: cpu_ack pulses in cycle 2, ld_ack stays 0.
- CPU read of addr 3 with RD_LAT=1 (RAM model returns A5). Required: cpu_ack at cycle 3 with cpu_rdata=A5, and ld_rdata unchanged.
- cpu_req and ld_req rise in the same cycle right after reset, then both re-request immediately.
  - Required grant order: CPU, then loader, then CPU (alternating owner).
  - Required: each ack occurs exactly once per transaction.
- ld_lock=1 with both requesting continuously.
  - Required: only the loader is granted and cpu_ack stays 0.
  - Then drop ld_lock: the CPU is granted at the next IDLE.
- reset driven low during WAIT of a loader read. Required: no ld_ack, all outputs at reset values on the next cycle, and mem_we never asserted.
- RD_LAT=3 build, loader read of addr 1F (RAM returns 3C). Required: ld_ack at cycle 5, ld_rdata=3C, and mem_addr=1F held in cycles 1–4.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Sequencer and two-way round-robin arbiter for the single-port
//            program/data RAM shared by the CPU control path and the
//            switch-driven program loader. One requester is granted at a
//            time; the granted access is driven onto the RAM port, the read
//            latency is waited out, and completion is signalled by a
//            one-cycle acknowledge to the owner.
//
// Ports    : CLOCK_50                      - sole clock, rising edge
//            reset                         - synchronous, active-low
//            cpu_req/we/addr/wdata         - CPU request (held until ack)
//            cpu_ack, cpu_rdata            - CPU completion pulse / read data
//            ld_req/we/addr/wdata          - loader request (same meaning)
//            ld_ack, ld_rdata              - loader completion / read data
//            ld_lock                       - loader exclusive, CPU not granted
//            mem_addr/we/wdata, mem_rdata  - RAM port
//            busy                          - transaction in progress
//            owner                         - 0 = CPU, 1 = loader
//
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int AW     = 5,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          CLOCK_50,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,

    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ack,
    output logic [DW-1:0] ld_rdata,
    input  logic          ld_lock,

    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy,
    output logic          owner
);

    // Counter wide enough to hold RD_LAT itself.
    localparam int unsigned           c_cnt_w   = $clog2(RD_LAT + 1);
    localparam logic [c_cnt_w-1:0]    c_rd_lat  = c_cnt_w'(RD_LAT);
    localparam logic [c_cnt_w-1:0]    c_cnt_one = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t               state_q,     state_d;
    logic                 owner_q,     owner_d;
    logic                 we_q,        we_d;
    logic [AW-1:0]        addr_q,      addr_d;
    logic [DW-1:0]        wdata_q,     wdata_d;
    logic                 last_q,      last_d;
    logic [c_cnt_w-1:0]   cnt_q,       cnt_d;
    logic [DW-1:0]        cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0]        ld_rdata_q,  ld_rdata_d;

    logic                 w_cpu_elig;
    logic                 w_ld_elig;
    logic                 w_grant_ld;
    logic                 w_last_wait;

    // ------------------------------------------------------------------
    // Arbitration. ld_lock removes the CPU from contention; on a tie the
    // requester not served last wins (last = 1 means loader went last, so
    // the CPU gets the grant).
    // ------------------------------------------------------------------
    assign w_cpu_elig  = cpu_req & ~ld_lock;
    assign w_ld_elig   = ld_req;
    assign w_grant_ld  = (w_cpu_elig & w_ld_elig) ? ~last_q : w_ld_elig;
    assign w_last_wait = (cnt_q == c_cnt_one);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        ld_rdata_d  = ld_rdata_q;

        unique case (state_q)
            S_IDLE: begin
                // Requests are only looked at here; the winner's command
                // is latched so later input changes cannot disturb it.
                if (w_cpu_elig | w_ld_elig) begin
                    owner_d = w_grant_ld;
                    if (w_grant_ld) begin
                        we_d    = ld_we;
                        addr_d  = ld_addr;
                        wdata_d = ld_wdata;
                    end else begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d   = c_rd_lat;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (w_last_wait) begin
                    // RAM data is valid in the final WAIT cycle; only the
                    // owner's rdata register is updated.
                    if (owner_q) begin
                        ld_rdata_d  = mem_rdata;
                    end else begin
                        cpu_rdata_d = mem_rdata;
                    end
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - c_cnt_one;
                end
            end

            S_ACK: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only, so no request input
    // reaches an output combinationally.
    // ------------------------------------------------------------------
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = (state_q == S_ISSUE) & we_q;
    assign cpu_ack   = (state_q == S_ACK) & ~owner_q;
    assign ld_ack    = (state_q == S_ACK) &  owner_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ld_rdata  = ld_rdata_q;
    assign busy      = (state_q != S_IDLE);
    assign owner     = owner_q;

endmodule
`default_nettype wire
